sr_p2s_feeder: RTL and testbench

//   Byte buffer and load sequencer placed directly upstream of the 8-bit parallel-to-serial shift register.

---
 rtl/sr_p2s_feeder.sv | 150 +++++++++++++++
 tb/tb_sr_p2s_feeder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_p2s_feeder.sv
// Byte FIFO and load sequencer feeding an 8-bit parallel-to-serial shifter.
// Optional synchronous flush input is enabled with `define SR_FEEDER_FLUSH_EN.
module sr_p2s_feeder #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SR_FEEDER_FLUSH_EN
    input  logic              flush,
`endif
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sr_ready,
    output logic              sr_load,
    output logic [7:0]        sr_data,
    output logic [ADDR_W:0]   count,
    output logic              empty
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

    state_t          state_q, state_d;
    logic            hold_q, hold_d;
    logic            sr_load_q, sr_load_d;
    logic [7:0]      sr_data_q, sr_data_d;
    logic            in_ready_q, in_ready_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            flush_req;

    // Pointers carry one extra wrap bit so the difference distinguishes full from empty.
    assign count_q    = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (count_q == '0);

`ifdef SR_FEEDER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        sr_load_d = 1'b0;
        sr_data_d = sr_data_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty && sr_ready) begin
                    pop       = 1'b1;
                    sr_load_d = 1'b1;
                    sr_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT;
                hold_d  = 1'b1;
            end
            WAIT: begin
                // The shifter's ready is registered, so its first post-load value is stale.
                if (hold_q) begin
                    hold_d = 1'b0;
                end else if (sr_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        sr_load_d = 1'b1;
                        sr_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
                        state_d   = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 1'b0;
            end
        endcase

        push = in_valid && in_ready_q && !flush_req;

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        if (flush_req) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            state_d   = IDLE;
            hold_d    = 1'b0;
            sr_load_d = 1'b0;
        end

        count_d    = wr_ptr_d - rd_ptr_d;
        in_ready_d = (count_d != FULL_CNT);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= 1'b0;
            sr_load_q  <= 1'b0;
            sr_data_q  <= 8'h00;
            in_ready_q <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            sr_load_q  <= sr_load_d;
            sr_data_q  <= sr_data_d;
            in_ready_q <= in_ready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign in_ready = in_ready_q;
    assign sr_load  = sr_load_q;
    assign sr_data  = sr_data_q;
    assign count    = count_q;
    assign empty    = fifo_empty;

endmodule

// File: tb/tb_sr_p2s_feeder.sv
// Directed self-checking bench for sr_p2s_feeder, including a behavioural
// MSB-first shifter model used for the streaming scenario.
module tb_sr_p2s_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sr_ready_drv = 1'b1;
    logic        use_model = 1'b0;
    logic        sr_ready;
    logic        sr_load;
    logic [7:0]  sr_data;
    logic [3:0]  count;
    logic        empty;
`ifdef SR_FEEDER_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  m_sh;
    int          m_cnt;
    logic        m_ready;
    logic [23:0] m_stream;
    int          m_bits;

    sr_p2s_feeder #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef SR_FEEDER_FLUSH_EN
        .flush    (flush),
`endif
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sr_ready (sr_ready),
        .sr_load  (sr_load),
        .sr_data  (sr_data),
        .count    (count),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign sr_ready = use_model ? m_ready : sr_ready_drv;

    // Shifter model: loads on sr_load, emits one bit per clock MSB first, ready registered.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sh     <= 8'h00;
            m_cnt    <= 0;
            m_ready  <= 1'b1;
            m_stream <= 24'h0;
            m_bits   <= 0;
        end else if (use_model) begin
            if (sr_load) begin
                m_sh     <= sr_data;
                m_cnt    <= 7;
                m_ready  <= 1'b0;
                m_stream <= {m_stream[22:0], sr_data[7]};
                m_bits   <= m_bits + 1;
            end else if (m_cnt > 0) begin
                m_sh     <= m_sh << 1;
                m_stream <= {m_stream[22:0], m_sh[6]};
                m_bits   <= m_bits + 1;
                m_cnt    <= m_cnt - 1;
                if (m_cnt == 1) m_ready <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sr_ready_drv = 1'b1;
        rst_n = 1'b0;
        tick();
        checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (sr_load !== 1'b0) begin errors++; $display("[TB] FAIL reset_sr_load: got %b expected 0", sr_load); end
        checks++; if (sr_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_sr_data: got %h expected 00", sr_data); end
        rst_n = 1'b1;
        tick();
        checks++; if (sr_load !== 1'b0 || count !== 4'd0) begin errors++; $display("[TB] FAIL post_reset_idle: got load=%b count=%0d expected 0/0", sr_load, count); end
    endtask

    task automatic test_single_push();
        do_reset();
        sr_ready_drv = 1'b1;
        in_data = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (sr_load !== 1'b0 || count !== 4'd1) begin errors++; $display("[TB] FAIL single_push_edge: got load=%b count=%0d expected 0/1", sr_load, count); end
        tick();
        checks++; if (sr_load !== 1'b1) begin errors++; $display("[TB] FAIL single_load: got %b expected 1", sr_load); end
        checks++; if (sr_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_data: got %h expected a5", sr_data); end
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL single_count: got %0d empty=%b expected 0/1", count, empty); end
        tick();
        checks++; if (sr_load !== 1'b0) begin errors++; $display("[TB] FAIL single_load_width: got %b expected 0", sr_load); end
    endtask

    task automatic test_full();
        bit found;
        do_reset();
        sr_ready_drv = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_data = 8'(i);
            in_valid = 1'b1;
            tick();
        end
        checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL full_count: got %0d expected 8", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b expected 0", in_ready); end
        in_data = 8'h09;
        tick();
        tick();
        checks++; if (count !== 4'd8 || sr_load !== 1'b0) begin errors++; $display("[TB] FAIL full_hold_off: got count=%0d load=%b expected 8/0", count, sr_load); end
        sr_ready_drv = 1'b1;
        tick();
        checks++; if (sr_load !== 1'b1 || sr_data !== 8'h01) begin errors++; $display("[TB] FAIL full_first_load: got load=%b data=%h expected 1/01", sr_load, sr_data); end
        checks++; if (count !== 4'd7 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_after_pop: got count=%0d in_ready=%b expected 7/1", count, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 4'd8 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_refill: got count=%0d in_ready=%b expected 8/0", count, in_ready); end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (sr_load) found = 1'b1;
        end
        checks++; if (!found || sr_data !== 8'h02) begin errors++; $display("[TB] FAIL full_second_load: got found=%b data=%h expected 1/02", found, sr_data); end
    endtask

    task automatic test_stream();
        int nloads;
        int ltime [4];
        logic [7:0] ldata [4];
        do_reset();
        use_model = 1'b1;
        nloads = 0;
        in_valid = 1'b1;
        in_data = 8'hF0;
        tick();
        if (sr_load) begin ltime[nloads] = cyc; ldata[nloads] = sr_data; nloads++; end
        in_data = 8'h0F;
        tick();
        if (sr_load) begin ltime[nloads] = cyc; ldata[nloads] = sr_data; nloads++; end
        in_data = 8'h3C;
        tick();
        in_valid = 1'b0;
        if (sr_load) begin ltime[nloads] = cyc; ldata[nloads] = sr_data; nloads++; end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (sr_load) begin
                if (nloads < 4) begin ltime[nloads] = cyc; ldata[nloads] = sr_data; end
                nloads++;
            end
        end
        checks++; if (nloads !== 3) begin errors++; $display("[TB] FAIL stream_loads: got %0d expected 3", nloads); end
        if (nloads >= 3) begin
            checks++; if (ltime[1] - ltime[0] !== 9) begin errors++; $display("[TB] FAIL stream_gap1: got %0d expected 9", ltime[1] - ltime[0]); end
            checks++; if (ltime[2] - ltime[1] !== 9) begin errors++; $display("[TB] FAIL stream_gap2: got %0d expected 9", ltime[2] - ltime[1]); end
            checks++; if ({ldata[0], ldata[1], ldata[2]} !== 24'hF00F3C) begin errors++; $display("[TB] FAIL stream_bytes: got %h%h%h expected f00f3c", ldata[0], ldata[1], ldata[2]); end
        end
        checks++; if (m_bits !== 24) begin errors++; $display("[TB] FAIL stream_bitcount: got %0d expected 24", m_bits); end
        checks++; if (m_stream !== 24'hF00F3C) begin errors++; $display("[TB] FAIL stream_serial: got %h expected f00f3c", m_stream); end
        use_model = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nloads;
        do_reset();
        sr_ready_drv = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        checks++; if (sr_load !== 1'b1 || sr_data !== 8'h11) begin errors++; $display("[TB] FAIL mid_setup_load: got load=%b data=%h expected 1/11", sr_load, sr_data); end
        sr_ready_drv = 1'b0;
        in_data = 8'h33;
        tick();
        in_data = 8'h44;
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 4'd3 || sr_load !== 1'b0) begin errors++; $display("[TB] FAIL mid_setup_count: got count=%0d load=%b expected 3/0", count, sr_load); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sr_load !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL mid_async_clear: got load=%b count=%0d empty=%b expected 0/0/1", sr_load, count, empty); end
        tick();
        rst_n = 1'b1;
        sr_ready_drv = 1'b1;
        nloads = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (sr_load) nloads++;
        end
        checks++; if (nloads !== 0 || count !== 4'd0) begin errors++; $display("[TB] FAIL mid_no_loads: got loads=%0d count=%0d expected 0/0", nloads, count); end
        // A strobe in flight must drop as soon as reset asserts.
        in_data = 8'h5A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sr_load !== 1'b0) begin errors++; $display("[TB] FAIL mid_load_drop: got %b expected 0", sr_load); end
        tick();
        rst_n = 1'b1;
    endtask

`ifdef SR_FEEDER_FLUSH_EN
    task automatic test_flush();
        int nloads;
        do_reset();
        sr_ready_drv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hC0 + 8'(i);
            in_valid = 1'b1;
            tick();
        end
        checks++; if (count !== 4'd4) begin errors++; $display("[TB] FAIL flush_setup: got %0d expected 4", count); end
        flush = 1'b1;
        in_data = 8'h55;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_clear: got count=%0d empty=%b in_ready=%b expected 0/1/1", count, empty, in_ready); end
        sr_ready_drv = 1'b1;
        nloads = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (sr_load) nloads++;
        end
        checks++; if (nloads !== 0 || count !== 4'd0) begin errors++; $display("[TB] FAIL flush_no_load: got loads=%0d count=%0d expected 0/0", nloads, count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_push();
        test_full();
        test_stream();
        test_reset_mid();
`ifdef SR_FEEDER_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
